// File: rtl/mm_job_sched_pkg.sv
// rtl/mm_job_sched_pkg.sv - shared encodings and constants for the matmul job scheduler
package mm_job_sched_pkg;

    localparam logic [1:0] MODE_INT8     = 2'd0;
    localparam logic [1:0] MODE_INT4     = 2'd1;
    localparam logic [1:0] MODE_INT4_VSQ = 2'd2;

    localparam int MM_N_TILES = 1024;
    localparam int MM_ADDR_W  = 16;
    localparam int TILE_CNT_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    // Tile counter sticks at all-ones so an overrun can never alias back to a clean count.
    function automatic logic [TILE_CNT_W-1:0] sat_inc_tile(input logic [TILE_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mm_job_sched_cmd_fifo.sv
// rtl/mm_job_sched_cmd_fifo.sv - synchronous command FIFO with flush, full/empty flags
module mm_job_sched_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign o_data  = mem_q[rd_ptr_q];

    // Flush beats a same-cycle push or pop.
    assign do_push = i_push & ~o_full & ~i_flush;
    assign do_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/mm_job_sched.sv
// rtl/mm_job_sched.sv - queues matmul jobs, issues them one at a time, relocates addresses, reports completion
// Optional: MM_JOB_PERF_EN adds o_done_cycles (ISSUE..mtrx_done cycle count).
module mm_job_sched
    import mm_job_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = MM_ADDR_W,
    parameter int N_TILES = MM_N_TILES
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_mode,
    input  logic [ADDR_W-1:0] i_cmd_a_base,
    input  logic [ADDR_W-1:0] i_cmd_b_base,
    input  logic [ID_W-1:0]   i_cmd_id,
    input  logic              i_flush,
    output logic              o_mm_start,
    output logic [1:0]        o_mm_mode,
    input  logic [ADDR_W-1:0] i_mm_a_addr,
    input  logic [ADDR_W-1:0] i_mm_b_addr,
    output logic [ADDR_W-1:0] o_a_addr,
    output logic [ADDR_W-1:0] o_b_addr,
    input  logic              i_mm_tile_done,
    input  logic              i_mm_mtrx_done,
    output logic              o_done_valid,
    input  logic              i_done_ready,
    output logic [ID_W-1:0]   o_done_id,
    output logic              o_done_err,
    output logic              o_busy
`ifdef MM_JOB_PERF_EN
    ,
    output logic [31:0]       o_done_cycles
`endif
);

    localparam int CMD_W = 2 + 2*ADDR_W + ID_W;

    state_e                state_q, state_d;
    logic [1:0]            mode_q;
    logic [ADDR_W-1:0]     a_base_q, b_base_q;
    logic [ID_W-1:0]       id_q;
    logic [TILE_CNT_W-1:0] tiles_q, tiles_d;
    logic                  err_q;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [CMD_W-1:0]      fifo_wdata, fifo_rdata;

    assign fifo_wdata = {i_cmd_mode, i_cmd_a_base, i_cmd_b_base, i_cmd_id};

    mm_job_sched_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_cmd_valid),
        .i_data  (fifo_wdata),
        .i_pop   (fifo_pop),
        .i_flush (i_flush),
        .o_data  (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // A flush in the same cycle as a pending launch drops that command instead of starting it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty && !i_flush) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_RUN;
            ST_RUN:    if (i_mm_mtrx_done) state_d = ST_REPORT;
            ST_REPORT: if (i_done_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_mm_start   = (state_q == ST_ISSUE);
        o_done_valid = (state_q == ST_REPORT);
        fifo_pop     = (state_q == ST_IDLE) && (state_d == ST_ISSUE);
    end

    always_comb begin
        tiles_d = tiles_q;
        if (fifo_pop)
            tiles_d = '0;
        else if (state_q == ST_RUN && i_mm_tile_done)
            tiles_d = sat_inc_tile(tiles_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q   <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            id_q     <= '0;
            tiles_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            tiles_q <= tiles_d;
            if (fifo_pop) {mode_q, a_base_q, b_base_q, id_q} <= fifo_rdata;
            if (state_q == ST_RUN && i_mm_mtrx_done)
                err_q <= (tiles_d != TILE_CNT_W'(N_TILES));
        end
    end

`ifdef MM_JOB_PERF_EN
    logic [31:0] cycles_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cycles_q <= '0;
        else if (fifo_pop)
            cycles_q <= '0;
        else if ((state_q == ST_ISSUE || state_q == ST_RUN) && !(&cycles_q))
            cycles_q <= cycles_q + 1'b1;
    end

    assign o_done_cycles = o_done_valid ? cycles_q : '0;
`endif

    assign o_cmd_ready = ~fifo_full;
    assign o_mm_mode   = mode_q;
    assign o_done_id   = id_q;
    assign o_done_err  = err_q;
    assign o_busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign o_a_addr    = i_mm_a_addr + a_base_q;
    assign o_b_addr    = i_mm_b_addr + b_base_q;

endmodule

// File: tb/tb_mm_job_sched.sv
// tb/tb_mm_job_sched.sv - self-checking bench for mm_job_sched against a queue-based job model
module tb_mm_job_sched;
    import mm_job_sched_pkg::*;

    localparam int DEPTH = 4, ID_W = 4, ADDR_W = 16, N_TILES = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              cmd_valid, flush, tile_done, mtrx_done, done_ready;
    logic [1:0]        cmd_mode;
    logic [ADDR_W-1:0] cmd_a_base, cmd_b_base, mm_a_addr, mm_b_addr;
    logic [ID_W-1:0]   cmd_id;
    logic              o_cmd_ready, o_mm_start, o_done_valid, o_done_err, o_busy;
    logic [1:0]        o_mm_mode;
    logic [ADDR_W-1:0] o_a_addr, o_b_addr;
    logic [ID_W-1:0]   o_done_id;

    mm_job_sched #(.DEPTH(DEPTH), .ID_W(ID_W), .ADDR_W(ADDR_W), .N_TILES(N_TILES)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_mode(cmd_mode),
        .i_cmd_a_base(cmd_a_base), .i_cmd_b_base(cmd_b_base), .i_cmd_id(cmd_id),
        .i_flush(flush), .o_mm_start(o_mm_start), .o_mm_mode(o_mm_mode),
        .i_mm_a_addr(mm_a_addr), .i_mm_b_addr(mm_b_addr), .o_a_addr(o_a_addr), .o_b_addr(o_b_addr),
        .i_mm_tile_done(tile_done), .i_mm_mtrx_done(mtrx_done),
        .o_done_valid(o_done_valid), .i_done_ready(done_ready), .o_done_id(o_done_id),
        .o_done_err(o_done_err), .o_busy(o_busy)
    );

    typedef struct {
        logic [1:0]        mode;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [ID_W-1:0]   id;
    } cmd_t;

    // Model: pending jobs, the job in flight, and where it is in its life (0 idle,1 issue,2 run,3 report).
    cmd_t       mq[$];
    cmd_t       mjob;
    int         mphase;
    int         mtiles;
    bit         merr;
    logic [1:0] mmode;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        mjob   = '{mode: 2'd0, a: '0, b: '0, id: '0};
        mphase = 0;
        mtiles = 0;
        merr   = 1'b0;
        mmode  = 2'd0;
    endfunction

    function automatic void model_edge();
        bit room;
        int nph;
        if (!rst_n) begin
            model_reset();
            return;
        end
        room = (mq.size() < DEPTH);
        nph  = mphase;
        case (mphase)
            0: if (mq.size() != 0 && !flush) begin
                   mjob   = mq.pop_front();
                   mmode  = mjob.mode;
                   mtiles = 0;
                   nph    = 1;
               end
            1: nph = 2;
            2: begin
                   if (tile_done) mtiles = (mtiles < 2047) ? mtiles + 1 : 2047;
                   if (mtrx_done) begin
                       merr = (mtiles != N_TILES);
                       nph  = 3;
                   end
               end
            default: if (done_ready) nph = 0;
        endcase
        mphase = nph;
        if (flush) mq.delete();
        else if (cmd_valid && room)
            mq.push_back('{mode: cmd_mode, a: cmd_a_base, b: cmd_b_base, id: cmd_id});
    endfunction

    function automatic void check_outputs();
        chk("cmd_ready", o_cmd_ready, mq.size() < DEPTH);
        chk("mm_start", o_mm_start, mphase == 1);
        chk("mm_mode", o_mm_mode, mmode);
        chk("done_valid", o_done_valid, mphase == 3);
        chk("busy", o_busy, (mphase != 0) || (mq.size() != 0));
        chk("a_addr", o_a_addr, ADDR_W'(mm_a_addr + mjob.a));
        chk("b_addr", o_b_addr, ADDR_W'(mm_b_addr + mjob.b));
        if (mphase == 3) begin
            chk("done_id", o_done_id, mjob.id);
            chk("done_err", o_done_err, merr);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic push(input logic [ID_W-1:0] id, input logic [1:0] mode,
                        input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        cmd_valid = 1'b1; cmd_id = id; cmd_mode = mode; cmd_a_base = a; cmd_b_base = b;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (o_mm_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("start_seen", o_mm_start, 1'b1);
    endtask

    logic [ID_W-1:0] ids[$];
    int              starts;

    initial begin
        rst_n = 1'b0;
        cmd_valid = 0; flush = 0; tile_done = 0; mtrx_done = 0; done_ready = 0;
        cmd_mode = 0; cmd_a_base = 0; cmd_b_base = 0; cmd_id = 0; mm_a_addr = 0; mm_b_addr = 0;
        model_reset();
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_start", o_mm_start, 0);
        chk("rst_done_valid", o_done_valid, 0);

        // Single INT8 job: start two cycles after the push, 1024 tiles, clean report.
        push(4'd3, MODE_INT8, 16'h0100, 16'h2000);
        chk("lat_t1_start", o_mm_start, 0);
        step();
        chk("lat_t2_start", o_mm_start, 1);
        chk("job3_mode", o_mm_mode, MODE_INT8);
        step();
        tile_done = 1;
        repeat (1024) step();
        tile_done = 0; mtrx_done = 1;
        step();
        mtrx_done = 0;
        chk("job3_valid", o_done_valid, 1);
        chk("job3_id", o_done_id, 3);
        chk("job3_err", o_done_err, 0);
        mm_a_addr = 16'h0004; mm_b_addr = 16'h0008;
        #1;
        chk("job3_a_reloc", o_a_addr, 16'h0104);
        chk("job3_b_reloc", o_b_addr, 16'h2008);
        done_ready = 1;
        step();
        done_ready = 0;
        chk("job3_idle_busy", o_busy, 0);

        // Address wrap and a short job (1000 tiles) flagged as an error.
        push(4'd7, MODE_INT4, 16'h0020, 16'h0000);
        wait_start();
        step();
        mm_a_addr = 16'hFFF0;
        #1;
        chk("a_addr_wrap", o_a_addr, 16'h0010);
        tile_done = 1;
        repeat (1000) step();
        tile_done = 0; mtrx_done = 1;
        step();
        mtrx_done = 0;
        chk("short_err", o_done_err, 1);
        done_ready = 1; step(); done_ready = 0;

        // 1023 tiles then a tile coincident with mtrx_done: exactly 1024, no error.
        push(4'd8, MODE_INT4_VSQ, 16'h1234, 16'h4321);
        wait_start();
        step();
        tile_done = 1;
        repeat (1023) step();
        mtrx_done = 1;
        step();
        tile_done = 0; mtrx_done = 0;
        chk("coinc_err", o_done_err, 0);
        chk("coinc_id", o_done_id, 8);
        done_ready = 1; step(); done_ready = 0;

        // Five commands queued behind a running job; ready drops when four are waiting.
        push(4'd9, MODE_INT8, 16'h0000, 16'h0000);
        wait_start();
        step();
        for (int k = 0; k < 4; k++) begin
            chk("fifo_rdy_before_push", o_cmd_ready, 1);
            push(ID_W'(10 + k), MODE_INT4, 16'(k), 16'(k * 2));
        end
        chk("fifo_full_rdy", o_cmd_ready, 0);
        cmd_valid = 1; cmd_id = 4'd14; mtrx_done = 1; done_ready = 1;
        ids.delete();
        for (int n = 0; n < 100 && ids.size() < 6; n++) begin
            if (o_done_valid) ids.push_back(o_done_id);
            if (cmd_valid && o_cmd_ready) begin
                step();
                cmd_valid = 0;
            end else begin
                step();
            end
        end
        mtrx_done = 0; done_ready = 0;
        chk("fifo_done_count", ids.size(), 6);
        for (int k = 0; k < ids.size(); k++) chk("fifo_order", ids[k], 9 + k);
        step();
        chk("fifo_drained_busy", o_busy, 0);

        // Completion held for 10 cycles: record stable, next queued job not started.
        push(4'd5, MODE_INT8, 16'h0040, 16'h0080);
        push(4'd6, MODE_INT4, 16'h0000, 16'h0000);
        wait_start();
        step();
        mtrx_done = 1; step(); mtrx_done = 0;
        for (int k = 0; k < 10; k++) begin
            chk("hold_valid", o_done_valid, 1);
            chk("hold_id", o_done_id, 5);
            chk("hold_no_start", o_mm_start, 0);
            step();
        end
        done_ready = 1; step(); done_ready = 0;
        chk("hold_released", o_done_valid, 0);
        step();
        chk("hold_next_start", o_mm_start, 1);
        step();
        mtrx_done = 1; step(); mtrx_done = 0;
        done_ready = 1; step(); done_ready = 0;

        // Flush during RUN: running job still reports, queued ones never start.
        push(4'd1, MODE_INT8, 16'h0000, 16'h0000);
        wait_start();
        step();
        push(4'd2, MODE_INT8, 16'h0000, 16'h0000);
        push(4'd3, MODE_INT8, 16'h0000, 16'h0000);
        push(4'd4, MODE_INT8, 16'h0000, 16'h0000);
        flush = 1; step(); flush = 0;
        mtrx_done = 1; step(); mtrx_done = 0;
        chk("flush_job_valid", o_done_valid, 1);
        chk("flush_job_id", o_done_id, 1);
        chk("flush_busy_report", o_busy, 1);
        done_ready = 1; step(); done_ready = 0;
        chk("flush_busy_after", o_busy, 0);
        starts = 0;
        repeat (20) begin
            step();
            if (o_mm_start) starts++;
        end
        chk("flush_no_starts", starts, 0);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int c = 0; c < 6000; c++) begin
            cmd_valid  = ($urandom_range(0, 2) == 0);
            cmd_mode   = 2'($urandom_range(0, 2));
            cmd_a_base = 16'($urandom);
            cmd_b_base = 16'($urandom);
            cmd_id     = 4'($urandom);
            flush      = ($urandom_range(0, 49) == 0);
            tile_done  = 1'($urandom_range(0, 1));
            mtrx_done  = ($urandom_range(0, 119) == 0);
            done_ready = 1'($urandom_range(0, 1));
            mm_a_addr  = 16'($urandom);
            mm_b_addr  = 16'($urandom);
            rst_n      = (c != 3000);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
